// File: rtl/uart_tx_msg_arbiter_pkg.sv
// Shared constants and types for the UART TX message arbiter.
// Latency: n/a (package only).
// Backpressure: n/a. UART_ARB_CRLF_EN adds the ST_CR state used for LF -> CR,LF expansion.
package uart_tx_msg_arbiter_pkg;

    localparam int NUM_CH = 4;

    localparam logic [1:0] CH_DHT11 = 2'd0;
    localparam logic [1:0] CH_SR04  = 2'd1;
    localparam logic [1:0] CH_KEY   = 2'd2;
    localparam logic [1:0] CH_TIME  = 2'd3;

    localparam logic [7:0] LF = 8'h0A;
    localparam logic [7:0] CR = 8'h0D;

`ifdef UART_ARB_CRLF_EN
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_CR   = 2'd2
    } arb_state_e;
`else
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1
    } arb_state_e;
`endif

    // Round-robin search: first requesting channel after 'last', wrapping.
    // Returns {found, index}.
    function automatic logic [2:0] rr_pick(input logic [3:0] req, input logic [1:0] last);
        logic [1:0] idx;
        logic       found;
        found   = 1'b0;
        rr_pick = 3'b000;
        for (int k = 1; k <= NUM_CH; k++) begin
            idx = last + 2'(k);
            if (!found && req[idx]) begin
                found   = 1'b1;
                rr_pick = {1'b1, idx};
            end
        end
    endfunction

endpackage

// File: rtl/uart_arb_chan_fifo.sv
// Per-channel synchronous byte FIFO with show-ahead read data.
// Latency: a byte written at edge k is visible on dout after edge k.
// Backpressure: none upstream; writes when full are dropped unless a pop happens in the same cycle.
module uart_arb_chan_fifo #(
    parameter int DEPTH = 16,
    parameter int W     = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [W-1:0] dout,
    output logic         empty,
    output logic         full
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem_q [DEPTH];
    logic [AW:0]  wr_ptr_q;
    logic [AW:0]  rd_ptr_q;
    logic         do_push;
    logic         do_pop;

    // A full buffer still accepts a write when the head leaves in the same cycle.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign dout  = mem_q[rd_ptr_q[AW-1:0]];

    // Pointer update; reset empties the buffer.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    // Storage write; contents need no reset since pointers gate visibility.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= din;
    end

endmodule

// File: rtl/uart_tx_msg_arbiter.sv
// Merges four ASCII byte streams into one TX FIFO push port, one whole message per grant (UART_ARB_CRLF_EN: LF sent as CR,LF).
// Latency: byte pushed at edge k into an idle arbiter -> grant at k+1, pop at k+2, o_push high the cycle after k+2.
// Backpressure: tx_full stalls the pop; sources cannot be stalled, so a full channel buffer drops and flags o_ovf.
module uart_tx_msg_arbiter
    import uart_tx_msg_arbiter_pkg::*;
#(
    parameter int         CH_DEPTH     = 16,
    parameter logic [7:0] EOL_CHAR     = 8'h0A,
    parameter int         MAX_MSG_LEN  = 32,
    parameter int         IDLE_TIMEOUT = 1000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push_dht11,
    input  logic       push_sr04,
    input  logic       push_key,
    input  logic       push_time,
    input  logic [7:0] ascii_dht11,
    input  logic [7:0] ascii_sr04,
    input  logic [7:0] ascii_key,
    input  logic [7:0] ascii_time,
    input  logic       tx_full,
    output logic       o_push,
    output logic [7:0] o_data,
    output logic       o_busy,
    output logic [3:0] o_ovf
);

    localparam int CW = $clog2(MAX_MSG_LEN + 1);
    localparam int TW = $clog2(IDLE_TIMEOUT + 1);
    localparam logic [CW-1:0] MAX_C = CW'(MAX_MSG_LEN);
    localparam logic [TW-1:0] TMO_C = TW'(IDLE_TIMEOUT);

    logic [3:0] push_vec;
    logic [7:0] din_vec  [NUM_CH];
    logic [7:0] dout_vec [NUM_CH];
    logic [3:0] empty_vec;
    logic [3:0] full_vec;
    logic [3:0] pop_vec;

    arb_state_e    state_q;
    logic [1:0]    gnt_q;
    logic [1:0]    rr_q;
    logic [CW-1:0] cnt_q;
    logic [TW-1:0] tmo_q;
    logic          o_push_q;
    logic [7:0]    o_data_q;
    logic          o_busy_q;
    logic [3:0]    o_ovf_q;

    logic [7:0] head;
    logic       head_vld;
    logic       can_send;
    logic       pop_en;
    logic [2:0] pick;

    assign push_vec = {push_time, push_key, push_sr04, push_dht11};
    assign din_vec[CH_DHT11] = ascii_dht11;
    assign din_vec[CH_SR04]  = ascii_sr04;
    assign din_vec[CH_KEY]   = ascii_key;
    assign din_vec[CH_TIME]  = ascii_time;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        uart_arb_chan_fifo #(
            .DEPTH (CH_DEPTH),
            .W     (8)
        ) u_fifo (
            .clk   (clk),
            .rst   (rst),
            .push  (push_vec[i]),
            .din   (din_vec[i]),
            .pop   (pop_vec[i]),
            .dout  (dout_vec[i]),
            .empty (empty_vec[i]),
            .full  (full_vec[i])
        );
    end

    assign head     = dout_vec[gnt_q];
    assign head_vld = !empty_vec[gnt_q];
    assign can_send = head_vld && !tx_full;
    assign pick     = rr_pick(~empty_vec, rr_q);
    assign pop_vec  = pop_en ? (4'b0001 << gnt_q) : 4'b0000;

    // Pop decision for the granted channel; the EOL stays queued while CR goes out first.
    always_comb begin
        pop_en = 1'b0;
        case (state_q)
`ifdef UART_ARB_CRLF_EN
            ST_SEND: pop_en = can_send && (head != EOL_CHAR);
            ST_CR:   pop_en = !tx_full;
`else
            ST_SEND: pop_en = can_send;
`endif
            default: pop_en = 1'b0;
        endcase
    end

    // Arbiter FSM with registered TX push/data, busy and sticky overflow flags.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            gnt_q    <= 2'd0;
            rr_q     <= 2'd3;
            cnt_q    <= '0;
            tmo_q    <= '0;
            o_push_q <= 1'b0;
            o_data_q <= 8'h00;
            o_busy_q <= 1'b0;
            o_ovf_q  <= 4'b0000;
        end else begin
            o_ovf_q  <= o_ovf_q | (push_vec & full_vec & ~pop_vec);
            o_push_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (pick[2]) begin
                        state_q  <= ST_SEND;
                        gnt_q    <= pick[1:0];
                        rr_q     <= pick[1:0];
                        cnt_q    <= '0;
                        tmo_q    <= '0;
                        o_busy_q <= 1'b1;
                    end
                end
                ST_SEND: begin
                    if (can_send) begin
                        tmo_q <= '0;
`ifdef UART_ARB_CRLF_EN
                        if (head == EOL_CHAR) begin
                            o_push_q <= 1'b1;
                            o_data_q <= CR;
                            state_q  <= ST_CR;
                        end else
`endif
                        begin
                            o_push_q <= 1'b1;
                            o_data_q <= head;
                            cnt_q    <= cnt_q + 1'b1;
                            if (head == EOL_CHAR || (cnt_q + 1'b1) == MAX_C) begin
                                state_q  <= ST_IDLE;
                                o_busy_q <= 1'b0;
                            end
                        end
                    end else if (!head_vld && !tx_full) begin
                        // Starved mid-message: give up the grant after a long gap.
                        tmo_q <= tmo_q + 1'b1;
                        if ((tmo_q + 1'b1) == TMO_C) begin
                            state_q  <= ST_IDLE;
                            o_busy_q <= 1'b0;
                        end
                    end
                end
`ifdef UART_ARB_CRLF_EN
                ST_CR: begin
                    if (!tx_full) begin
                        o_push_q <= 1'b1;
                        o_data_q <= LF;
                        state_q  <= ST_IDLE;
                        o_busy_q <= 1'b0;
                    end
                end
`endif
                default: begin
                    state_q  <= ST_IDLE;
                    o_busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign o_push = o_push_q;
    assign o_data = o_data_q;
    assign o_busy = o_busy_q;
    assign o_ovf  = o_ovf_q;

endmodule

// File: tb/tb_uart_tx_msg_arbiter.sv
// Bench for uart_tx_msg_arbiter: directed vectors, corner sequences and a randomized message-level model.
// Latency: n/a.
// Backpressure: tx_full is driven both deterministically and randomly.
module tb_uart_tx_msg_arbiter;

    localparam int CH_DEPTH = 16;
    localparam int MAX_LEN  = 32;
    localparam int IDLE_TO  = 1000;

    typedef logic [7:0] bq_t[$];

    typedef struct {
        logic       p;
        logic [7:0] b;
        logic       ep;
        logic [7:0] ed;
        logic       eb;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] p_v = 4'b0000;
    logic [7:0] b_v [4];
    logic       tx_full = 1'b0;
    logic       o_push;
    logic [7:0] o_data;
    logic       o_busy;
    logic [3:0] o_ovf;

    int n_pass  = 0;
    int n_total = 0;
    int cyc     = 0;

    logic [7:0] log_dat[$];
    int         log_cyc[$];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (o_push === 1'b1) begin
            log_dat.push_back(o_data);
            log_cyc.push_back(cyc);
        end
    end

    uart_tx_msg_arbiter #(
        .CH_DEPTH     (CH_DEPTH),
        .EOL_CHAR     (8'h0A),
        .MAX_MSG_LEN  (MAX_LEN),
        .IDLE_TIMEOUT (IDLE_TO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .push_dht11  (p_v[0]),
        .push_sr04   (p_v[1]),
        .push_key    (p_v[2]),
        .push_time   (p_v[3]),
        .ascii_dht11 (b_v[0]),
        .ascii_sr04  (b_v[1]),
        .ascii_key   (b_v[2]),
        .ascii_time  (b_v[3]),
        .tx_full     (tx_full),
        .o_push      (o_push),
        .o_data      (o_data),
        .o_busy      (o_busy),
        .o_ovf       (o_ovf)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    task automatic clr();
        p_v = 4'b0000;
    endtask

    task automatic clear_log();
        log_dat.delete();
        log_cyc.delete();
    endtask

    task automatic do_reset();
        clr();
        tx_full = 1'b0;
        rst = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        clear_log();
    endtask

    function automatic logic [7:0] lb(input int i);
        if (i < log_dat.size()) return log_dat[i];
        return 8'hxx;
    endfunction

    function automatic int lc(input int i);
        if (i < log_cyc.size()) return log_cyc[i];
        return -1;
    endfunction

    task automatic chk_log(input string name, input bq_t exp);
        chk({name, "_len"}, log_dat.size(), exp.size());
        foreach (exp[i]) chk(name, lb(i), exp[i]);
    endtask

    // Random-phase reference: per-channel queues of bytes still owed on the TX port.
    bq_t mq [4];
    bq_t tp [4];
    int  owner  = -1;
    int  rd_idx = 0;

    task automatic consume_log();
        logic [7:0] x;
        logic [7:0] e;
        while (rd_idx < log_dat.size()) begin
            x = log_dat[rd_idx];
            rd_idx++;
            if (owner < 0) begin
                chk("rnd_msg_start_is_letter", (x >= 8'h41 && x <= 8'h58), 1);
                if (x >= 8'h41 && x <= 8'h58) owner = int'(x - 8'h41) / 6;
            end
            if (owner >= 0) begin
                e = (mq[owner].size() > 0) ? mq[owner].pop_front() : 8'hxx;
                chk("rnd_byte", x, e);
                if (x == 8'h0A) owner = -1;
            end
        end
    endtask

    vec_t tv [8];
    bq_t  s_sr, s_tm, s_fair, s_hello, s_ovf, s_msg, s_tmo;

    initial begin
        for (int i = 0; i < 4; i++) b_v[i] = 8'h00;

        // Single message "T25\n" on dht11: per-cycle expected push/data/busy after each edge.
        tv[0] = '{1'b1, 8'h54, 1'b0, 8'h00, 1'b0};
        tv[1] = '{1'b1, 8'h32, 1'b0, 8'h00, 1'b1};
        tv[2] = '{1'b1, 8'h35, 1'b1, 8'h54, 1'b1};
        tv[3] = '{1'b1, 8'h0A, 1'b1, 8'h32, 1'b1};
        tv[4] = '{1'b0, 8'h00, 1'b1, 8'h35, 1'b1};
        tv[5] = '{1'b0, 8'h00, 1'b1, 8'h0A, 1'b0};
        tv[6] = '{1'b0, 8'h00, 1'b0, 8'h0A, 1'b0};
        tv[7] = '{1'b0, 8'h00, 1'b0, 8'h0A, 1'b0};

        s_sr    = '{8'h44, 8'h31, 8'h32, 8'h0A};
        s_tm    = '{8'h31, 8'h32, 8'h3A, 8'h30, 8'h30, 8'h0A};
        s_fair  = '{8'h41, 8'h0A, 8'h4B, 8'h0A, 8'h41, 8'h0A, 8'h4B, 8'h0A, 8'h41, 8'h0A, 8'h4B, 8'h0A};
        s_hello = '{8'h48, 8'h45, 8'h4C, 8'h4C, 8'h4F, 8'h0A};
        s_msg   = '{8'h4D, 8'h53, 8'h47, 8'h31, 8'h32};
        s_tmo   = '{8'h41, 8'h42, 8'h58, 8'h0A};

        // Reset state
        do_reset();
        chk("rst_push", o_push, 0);
        chk("rst_busy", o_busy, 0);
        chk("rst_ovf",  o_ovf,  0);
        chk("rst_data", o_data, 0);

        // Single message vectors
        for (int i = 0; i < 8; i++) begin
            p_v[0] = tv[i].p;
            b_v[0] = tv[i].b;
            tick();
            chk($sformatf("single_push[%0d]", i), o_push, tv[i].ep);
            chk($sformatf("single_data[%0d]", i), o_data, tv[i].ed);
            chk($sformatf("single_busy[%0d]", i), o_busy, tv[i].eb);
        end
        clr();

        // Contention: sr04 and time start together, no interleaving, one idle cycle between
        do_reset();
        for (int i = 0; i < 6; i++) begin
            p_v[1] = (i < 4);
            b_v[1] = (i < 4) ? s_sr[i] : 8'h00;
            p_v[3] = 1'b1;
            b_v[3] = s_tm[i];
            tick();
        end
        clr();
        repeat (20) tick();
        chk_log("contention", {s_sr, s_tm});
        chk("contention_gap", lc(4) - lc(3), 2);

        // Round-robin fairness between dht11 and key
        do_reset();
        for (int i = 0; i < 6; i++) begin
            p_v[0] = 1'b1;
            b_v[0] = (i % 2 == 0) ? 8'h41 : 8'h0A;
            p_v[2] = 1'b1;
            b_v[2] = (i % 2 == 0) ? 8'h4B : 8'h0A;
            tick();
        end
        clr();
        repeat (30) tick();
        chk_log("fairness", s_fair);

        // Back-pressure mid-message for 10 cycles
        do_reset();
        for (int i = 0; i < 6; i++) begin
            p_v[3] = 1'b1;
            b_v[3] = s_hello[i];
            if (i == 3) tx_full = 1'b1;
            tick();
            if (i >= 3) chk($sformatf("stall_push[%0d]", i), o_push, 0);
        end
        clr();
        for (int i = 0; i < 7; i++) begin
            tick();
            chk($sformatf("stall_push_tail[%0d]", i), o_push, 0);
        end
        chk("stall_busy", o_busy, 1);
        tx_full = 1'b0;
        repeat (20) tick();
        chk_log("backpressure", s_hello);

        // Overflow: 17 bytes into key while TX is full
        do_reset();
        tx_full = 1'b1;
        s_ovf = {};
        for (int i = 0; i < 17; i++) begin
            p_v[2] = 1'b1;
            b_v[2] = 8'h61 + 8'(i);
            if (i < 16) s_ovf.push_back(8'h61 + 8'(i));
            tick();
        end
        clr();
        tick();
        chk("ovf_flags", o_ovf, 4'b0100);
        chk("ovf_busy_held", o_busy, 1);
        tx_full = 1'b0;
        repeat (IDLE_TO + 50) tick();
        chk_log("ovf_retained", s_ovf);
        chk("ovf_timeout_release", o_busy, 0);
        chk("ovf_sticky", o_ovf, 4'b0100);

        // Reset mid-message: partial message discarded, flags cleared
        clear_log();
        for (int i = 0; i < 5; i++) begin
            p_v[3] = 1'b1;
            b_v[3] = s_msg[i];
            tick();
        end
        clr();
        chk("mid_pre_count", log_dat.size(), 3);
        chk("mid_pre_busy", o_busy, 1);
        rst = 1'b0;
        tick();
        chk("mid_rst_push", o_push, 0);
        chk("mid_rst_busy", o_busy, 0);
        chk("mid_rst_ovf",  o_ovf,  0);
        rst = 1'b1;
        clear_log();
        repeat (30) tick();
        chk("mid_no_stale_bytes", log_dat.size(), 0);
        chk("mid_idle_busy", o_busy, 0);

        // Idle timeout on dht11 "AB", then sr04 served
        for (int i = 0; i < 2; i++) begin
            p_v[0] = 1'b1;
            b_v[0] = s_tmo[i];
            tick();
        end
        clr();
        repeat (3) tick();
        for (int i = 2; i < 4; i++) begin
            p_v[1] = 1'b1;
            b_v[1] = s_tmo[i];
            tick();
        end
        clr();
        repeat (IDLE_TO - 20) tick();
        chk("tmo_still_locked", o_busy, 1);
        repeat (60) tick();
        chk_log("timeout", s_tmo);
        chk("timeout_gap", lc(2) - lc(1), IDLE_TO + 2);
        chk("timeout_busy", o_busy, 0);

        // Randomized traffic against the message-level model
        do_reset();
        owner  = -1;
        rd_idx = 0;
        for (int c = 0; c < 3000; c++) begin
            for (int ch = 0; ch < 4; ch++) begin
                if (tp[ch].size() == 0 && $urandom_range(7) == 0) begin
                    int len;
                    len = int'($urandom_range(4, 1));
                    if (mq[ch].size() + len + 1 <= CH_DEPTH) begin
                        for (int k = 0; k < len; k++) begin
                            logic [7:0] ltr;
                            ltr = 8'h41 + 8'(6 * ch) + 8'($urandom_range(5));
                            mq[ch].push_back(ltr);
                            tp[ch].push_back(ltr);
                        end
                        mq[ch].push_back(8'h0A);
                        tp[ch].push_back(8'h0A);
                    end
                end
                if (tp[ch].size() > 0) begin
                    p_v[ch] = 1'b1;
                    b_v[ch] = tp[ch].pop_front();
                end else begin
                    p_v[ch] = 1'b0;
                end
            end
            tx_full = ($urandom_range(3) == 0);
            tick();
            consume_log();
        end
        clr();
        tx_full = 1'b0;
        repeat (200) begin
            tick();
            consume_log();
        end
        for (int ch = 0; ch < 4; ch++) chk($sformatf("rnd_drained[%0d]", ch), mq[ch].size(), 0);
        chk("rnd_ovf", o_ovf, 0);
        chk("rnd_busy_end", o_busy, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
